// File: rtl/psum_accumulator_if.sv
// Bundles the command, product and result channels of the partial-sum stage.
// Latency: none. The interface only carries wires.
// Backpressure: each channel uses valid/ready. Status flags (done/err/ovf) have no handshake.
interface psum_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 24,
  parameter int IDX_W  = 2
);
  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [1:0]               cmd_op;
  logic                     prod_valid;
  logic                     prod_ready;
  logic signed [PROD_W-1:0] prod_data;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [ACC_W-1:0]  out_data;
  logic                     out_spike;
  logic [IDX_W-1:0]         out_index;
  logic                     done;
  logic                     err;
  logic                     ovf;

  // Upstream controller / multiplier / neuron side
  modport master (
    output cmd_valid, cmd_op, prod_valid, prod_data, out_ready,
    input  cmd_ready, prod_ready, out_valid, out_data, out_spike, out_index, done, err, ovf
  );

  // Accumulator side
  modport slave (
    input  cmd_valid, cmd_op, prod_valid, prod_data, out_ready,
    output cmd_ready, prod_ready, out_valid, out_data, out_spike, out_index, done, err, ovf
  );
endinterface

// File: rtl/psum_accumulator.sv
// Saturating signed partial-sum accumulator. It takes clear/add/emit commands and emits the sum with a spike flag.
// Latency: a command lifts prod_ready/out_valid the next cycle. A product updates acc and re-arms cmd_ready the next cycle.
// Backpressure: one command at a time. S_ADD waits for prod_valid and S_EMIT holds the result until out_ready.
module psum_accumulator #(
  parameter int PROD_W      = 16,
  parameter int ACC_W       = 24,
  parameter int FILTER_LEN  = 3,
  parameter int NUM_OUTPUTS = 3,
  parameter int THRESH      = 64
) (
  input  logic              clk,
  input  logic              reset,
  psum_accumulator_if.slave bus
);
  localparam int IDX_W = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
  localparam int CNT_W = $clog2(FILTER_LEN + 2);

  localparam logic [1:0] OP_ADD   = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_EMIT  = 2'b10;

  localparam logic signed [ACC_W-1:0] ACC_MAX  = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN  = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] THR      = ACC_W'(THRESH);
  localparam logic [CNT_W-1:0]        CNT_MAX  = CNT_W'(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0]        CNT_EXP  = CNT_W'(FILTER_LEN);
  localparam logic [IDX_W-1:0]        IDX_LAST = IDX_W'(NUM_OUTPUTS - 1);

  typedef enum logic [1:0] {S_CMD, S_ADD, S_EMIT} state_t;

  state_t                   r_state,     w_state_nxt;
  logic signed [ACC_W-1:0]  r_acc,       w_acc_nxt;
  logic [CNT_W-1:0]         r_cnt,       w_cnt_nxt;
  logic [IDX_W-1:0]         r_idx,       w_idx_nxt;
  logic signed [ACC_W-1:0]  r_data,      w_data_nxt;
  logic                     r_spike,     w_spike_nxt;
  logic                     r_done,      w_done_nxt;
  logic                     r_err,       w_err_nxt;
  logic                     r_ovf,       w_ovf_nxt;
  logic                     r_cmd_rdy,   w_cmd_rdy_nxt;
  logic                     r_prod_rdy,  w_prod_rdy_nxt;
  logic                     r_out_vld,   w_out_vld_nxt;

  logic                     w_cmd_fire;
  logic                     w_prod_fire;
  logic                     w_out_fire;
  logic signed [ACC_W:0]    w_sum;
  logic                     w_clamp;
  logic signed [ACC_W-1:0]  w_sat;

  // The ready/valid flags are registered, so a handshake only needs the flag of the owning state.
  assign w_cmd_fire  = bus.cmd_valid  & r_cmd_rdy;
  assign w_prod_fire = bus.prod_valid & r_prod_rdy;
  assign w_out_fire  = bus.out_ready  & r_out_vld;

  // One guard bit above ACC_W catches the overflow. The top two bits disagree exactly when the sum left the range.
  assign w_sum   = {r_acc[ACC_W-1], r_acc}
                 + {{(ACC_W + 1 - PROD_W){bus.prod_data[PROD_W-1]}}, bus.prod_data};
  assign w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];
  assign w_sat   = w_clamp ? (w_sum[ACC_W] ? ACC_MIN : ACC_MAX) : w_sum[ACC_W-1:0];

  // Next-state, datapath updates and next values of the registered handshake flags
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_idx_nxt   = r_idx;
    w_data_nxt  = r_data;
    w_spike_nxt = r_spike;
    w_done_nxt  = 1'b0;
    w_err_nxt   = r_err;
    w_ovf_nxt   = r_ovf;
    unique case (r_state)
      S_CMD: begin
        if (w_cmd_fire) begin
          case (bus.cmd_op)
            OP_CLEAR: begin
              w_acc_nxt = '0;
              w_cnt_nxt = '0;
              w_ovf_nxt = 1'b0;
            end
            OP_ADD:  w_state_nxt = S_ADD;
            OP_EMIT: begin
              w_data_nxt  = r_acc;
              w_spike_nxt = (r_acc >= THR);
              w_state_nxt = S_EMIT;
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end
      S_ADD: begin
        if (w_prod_fire) begin
          w_acc_nxt   = w_sat;
          w_ovf_nxt   = r_ovf | w_clamp;
          w_cnt_nxt   = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;
          w_state_nxt = S_CMD;
        end
      end
      S_EMIT: begin
        if (w_out_fire) begin
          if (r_cnt != CNT_EXP) w_err_nxt = 1'b1;
          if (r_idx == IDX_LAST) begin
            w_idx_nxt  = '0;
            w_done_nxt = 1'b1;
          end else begin
            w_idx_nxt = r_idx + 1'b1;
          end
          w_state_nxt = S_CMD;
        end
      end
      default: w_state_nxt = S_CMD;
    endcase
    w_cmd_rdy_nxt  = (w_state_nxt == S_CMD);
    w_prod_rdy_nxt = (w_state_nxt == S_ADD);
    w_out_vld_nxt  = (w_state_nxt == S_EMIT);
  end

  // State and every visible output are registered. Reset drops all handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_CMD;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_data     <= '0;
      r_spike    <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_ovf      <= 1'b0;
      r_cmd_rdy  <= 1'b0;
      r_prod_rdy <= 1'b0;
      r_out_vld  <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_acc      <= w_acc_nxt;
      r_cnt      <= w_cnt_nxt;
      r_idx      <= w_idx_nxt;
      r_data     <= w_data_nxt;
      r_spike    <= w_spike_nxt;
      r_done     <= w_done_nxt;
      r_err      <= w_err_nxt;
      r_ovf      <= w_ovf_nxt;
      r_cmd_rdy  <= w_cmd_rdy_nxt;
      r_prod_rdy <= w_prod_rdy_nxt;
      r_out_vld  <= w_out_vld_nxt;
    end
  end

  assign bus.cmd_ready  = r_cmd_rdy;
  assign bus.prod_ready = r_prod_rdy;
  assign bus.out_valid  = r_out_vld;
  assign bus.out_data   = r_data;
  assign bus.out_spike  = r_spike;
  assign bus.out_index  = r_idx;
  assign bus.done       = r_done;
  assign bus.err        = r_err;
  assign bus.ovf        = r_ovf;
endmodule

// File: tb/tb_psum_accumulator.sv
// Bench for psum_accumulator: directed scenarios plus random groups against a transaction-level model.
// Latency: the model is updated at each handshake edge and compared on the following falling edge.
// Backpressure: random out_ready holds. Every wait is bounded by a cycle budget.
module tb_psum_accumulator;
  localparam int PROD_W      = 16;
  localparam int ACC_W       = 24;
  localparam int FILTER_LEN  = 3;
  localparam int NUM_OUTPUTS = 3;
  localparam int THRESH      = 64;
  localparam int IDX_W       = 2;
  localparam int BUDGET      = 400;
  localparam longint ACC_MAXV = 64'sd8388607;
  localparam longint ACC_MINV = -64'sd8388608;
  localparam logic [1:0] OP_ADD = 2'b00, OP_CLEAR = 2'b01, OP_EMIT = 2'b10, OP_RSVD = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  psum_accumulator_if #(.PROD_W(PROD_W), .ACC_W(ACC_W), .IDX_W(IDX_W)) bus ();

  psum_accumulator #(
    .PROD_W(PROD_W), .ACC_W(ACC_W), .FILTER_LEN(FILTER_LEN),
    .NUM_OUTPUTS(NUM_OUTPUTS), .THRESH(THRESH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave)
  );

  // Transaction-level model state
  longint m_acc, m_out;
  int     m_cnt, m_idx;
  bit     m_err, m_ovf, m_done, m_add, m_emit, m_armed;
  bit     chk_on = 1'b0;

  int total = 0;
  int bad   = 0;

  longint last_data;
  int     last_spike, last_idx, d1, d2;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    total++;
    bad++;
    $display("FAIL timeout waiting for %s", nm);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "bench stalled");
  endtask

  task automatic model_reset();
    m_acc = 0; m_out = 0; m_cnt = 0; m_idx = 0;
    m_err = 0; m_ovf = 0; m_done = 0; m_add = 0; m_emit = 0; m_armed = 0;
  endtask

  // Per-cycle comparison of the DUT against the model
  always @(negedge clk) begin
    if (!reset && chk_on) begin
      chk("out_valid", longint'(bus.out_valid), longint'(m_emit));
      chk("prod_ready", longint'(bus.prod_ready), longint'(m_add));
      if (m_emit || m_add) chk("cmd_ready_busy", longint'(bus.cmd_ready), 0);
      else if (m_armed)    chk("cmd_ready_idle", longint'(bus.cmd_ready), 1);
      if (bus.out_valid) begin
        chk("out_data", longint'(bus.out_data), m_out);
        chk("out_spike", longint'(bus.out_spike), longint'(m_out >= THRESH));
        chk("out_index", longint'(bus.out_index), longint'(m_idx));
      end
      chk("err", longint'(bus.err), longint'(m_err));
      chk("ovf", longint'(bus.ovf), longint'(m_ovf));
      chk("done", longint'(bus.done), longint'(m_done));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b1;
    bus.cmd_valid = 1'b0; bus.prod_valid = 1'b0; bus.out_ready = 1'b0;
    model_reset();
    #1;
    chk("rst_cmd_ready", longint'(bus.cmd_ready), 0);
    chk("rst_prod_ready", longint'(bus.prod_ready), 0);
    chk("rst_out_valid", longint'(bus.out_valid), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_spike", longint'(bus.out_spike), 0);
    chk("rst_data", longint'(bus.out_data), 0);
    chk("rst_err", longint'(bus.err), 0);
    chk("rst_ovf", longint'(bus.ovf), 0);
    chk("rst_index", longint'(bus.out_index), 0);
    @(negedge clk);
    #2;
    reset = 1'b0;
  endtask

  task automatic do_cmd(input logic [1:0] op);
    int n;
    n = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    while (!bus.cmd_ready) begin
      if (n >= BUDGET) timeout("cmd_ready");
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    m_armed = 1;
    case (op)
      OP_CLEAR: begin m_acc = 0; m_cnt = 0; m_ovf = 0; end
      OP_ADD:   m_add = 1;
      OP_EMIT:  begin m_emit = 1; m_out = m_acc; end
      default:  m_err = 1;
    endcase
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic do_add(input int p);
    int n;
    longint s;
    do_cmd(OP_ADD);
    n = 0;
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod_data  = p[PROD_W-1:0];
    while (!bus.prod_ready) begin
      if (n >= BUDGET) timeout("prod_ready");
      n++;
      @(negedge clk);
    end
    @(posedge clk);
    s = m_acc + longint'(p);
    if (s > ACC_MAXV) begin s = ACC_MAXV; m_ovf = 1; end
    if (s < ACC_MINV) begin s = ACC_MINV; m_ovf = 1; end
    m_acc = s;
    if (m_cnt < FILTER_LEN + 1) m_cnt++;
    m_add = 0;
    #1 bus.prod_valid = 1'b0;
  endtask

  task automatic take_out(input int hold);
    int n;
    bit wrap;
    n = 0;
    @(negedge clk);
    while (!bus.out_valid) begin
      if (n >= BUDGET) timeout("out_valid");
      n++;
      @(negedge clk);
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("bp_valid", longint'(bus.out_valid), 1);
      chk("bp_data", longint'(bus.out_data), m_out);
      chk("bp_cmd_ready", longint'(bus.cmd_ready), 0);
    end
    last_data  = longint'(bus.out_data);
    last_spike = int'(bus.out_spike);
    last_idx   = int'(bus.out_index);
    bus.out_ready = 1'b1;
    @(posedge clk);
    if (m_cnt != FILTER_LEN) m_err = 1;
    wrap   = (m_idx == NUM_OUTPUTS - 1);
    m_idx  = wrap ? 0 : m_idx + 1;
    m_done = wrap;
    m_emit = 0;
    #1 bus.out_ready = 1'b0;
    @(negedge clk);
    d1 = int'(bus.done);
    @(posedge clk);
    m_done = 0;
    #1 d2 = int'(bus.done);
  endtask

  task automatic group3(input int a, input int b, input int c, input int hold);
    do_cmd(OP_CLEAR);
    do_add(a);
    do_add(b);
    do_add(c);
    do_cmd(OP_EMIT);
    take_out(hold);
  endtask

  initial begin
    bus.cmd_valid = 1'b0; bus.cmd_op = OP_ADD;
    bus.prod_valid = 1'b0; bus.prod_data = '0; bus.out_ready = 1'b0;
    model_reset();
    do_reset();
    chk_on = 1'b1;

    // Nominal positions
    group3(10, 20, 40, 0);
    chk("nom_data", last_data, 70);
    chk("nom_spike", last_spike, 1);
    chk("nom_index", last_idx, 0);
    chk("nom_err", longint'(bus.err), 0);
    group3(5, -3, 2, 0);
    chk("nom2_data", last_data, 4);
    chk("nom2_spike", last_spike, 0);
    chk("nom2_index", last_idx, 1);
    group3(1, 2, 3, 0);
    chk("nom3_index", last_idx, 2);
    chk("done_pulse", d1, 1);
    chk("done_clear", d2, 0);
    chk("index_wrap", longint'(bus.out_index), 0);

    // Back-pressure for 5 cycles
    group3(100, -50, 7, 5);
    chk("bp_final_data", last_data, 57);
    chk("bp_nodone", d1, 0);

    // Products offered outside S_ADD are not taken
    @(negedge clk);
    bus.prod_valid = 1'b1;
    bus.prod_data  = 16'sd123;
    repeat (3) begin
      @(negedge clk);
      chk("idle_prod_ready", longint'(bus.prod_ready), 0);
    end
    bus.prod_valid = 1'b0;

    // Saturation
    do_cmd(OP_CLEAR);
    repeat (300) do_add(32767);
    do_cmd(OP_EMIT);
    take_out(1);
    chk("sat_data", last_data, 8388607);
    chk("sat_ovf", longint'(bus.ovf), 1);
    chk("sat_err", longint'(bus.err), 1);
    do_cmd(OP_CLEAR);
    chk("sat_clear_ovf", longint'(bus.ovf), 0);

    // Short group flags err but still emits
    do_reset();
    do_cmd(OP_CLEAR);
    do_add(9);
    do_add(9);
    do_cmd(OP_EMIT);
    take_out(0);
    chk("short_data", last_data, 18);
    chk("short_err", longint'(bus.err), 1);

    // Reserved opcode sets err and leaves acc alone
    do_reset();
    do_cmd(OP_CLEAR);
    do_add(7);
    do_cmd(OP_RSVD);
    chk("rsvd_err", longint'(bus.err), 1);
    do_cmd(OP_EMIT);
    take_out(0);
    chk("rsvd_acc", last_data, 7);

    // Random groups
    do_reset();
    for (int g = 0; g < 60; g++) begin
      int nadd;
      if ($urandom_range(0, 9) != 0) do_cmd(OP_CLEAR);
      if ($urandom_range(0, 14) == 0) do_cmd(OP_RSVD);
      nadd = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 5)) : 3;
      for (int k = 0; k < nadd; k++) begin
        logic signed [15:0] rp;
        rp = 16'($urandom);
        if ($urandom_range(0, 3) != 0) rp = 16'(int'($urandom_range(0, 400)) - 200);
        do_add(int'(rp));
      end
      do_cmd(OP_EMIT);
      take_out(int'($urandom_range(0, 3)));
    end

    // Reset while waiting for a product
    do_reset();
    group3(1, 1, 1, 0);
    do_cmd(OP_RSVD);
    do_cmd(OP_ADD);
    @(negedge clk);
    #2;
    bus.prod_valid = 1'b1;
    bus.prod_data  = 16'sd500;
    reset = 1'b1;
    model_reset();
    #1;
    chk("midrst_prod_ready", longint'(bus.prod_ready), 0);
    chk("midrst_err", longint'(bus.err), 0);
    chk("midrst_index", longint'(bus.out_index), 0);
    chk("midrst_data", longint'(bus.out_data), 0);
    @(negedge clk);
    #2;
    bus.prod_valid = 1'b0;
    reset = 1'b0;
    do_cmd(OP_EMIT);
    take_out(0);
    chk("midrst_acc", last_data, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
